// File: rtl/bit_scan_pkg.sv
// ============================================================================
// bit_scan_pkg : shared mode encodings and helpers for the bit-scan unit
// Revision 1.0
// ============================================================================
`default_nettype none

package bit_scan_pkg;

    localparam logic [1:0] MODE_CLZ = 2'b00;
    localparam logic [1:0] MODE_CLO = 2'b01;
    localparam logic [1:0] MODE_CTZ = 2'b10;
    localparam logic [1:0] MODE_CTO = 2'b11;

    localparam int MAX_W = 64;

    // Reverses the low w bits of d into the low w bits of the result.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = d[w-1-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lzc_tree.sv
// ============================================================================
// lzc_tree : combinational leading-zero counter built from halving selects
// Revision 1.0
// ============================================================================
`default_nettype none

module lzc_tree #(
    parameter int WIDTH    = 32,
    parameter int RESULT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]    data,
    output logic [RESULT_W-1:0] count,
    output logic                all_zero
);

    localparam int LOG = $clog2(WIDTH);

    logic [WIDTH-1:0] w_win [0:LOG-1];
    logic [LOG-1:0]   w_cnt;

    assign w_win[0] = data;

    // Each level tests the top half of the current window; a zero half is shifted out.
    for (genvar g = 0; g < LOG; g++) begin : g_level
        localparam int HALF = WIDTH >> (g + 1);
        assign w_cnt[LOG-1-g] = (w_win[g][WIDTH-1 -: HALF] == '0);
        if (g < LOG - 1) begin : g_next
            assign w_win[g+1] = w_cnt[LOG-1-g] ? (w_win[g] << HALF) : w_win[g];
        end
    end

    // Shifts never discard a set bit, so the last window is zero only for a zero operand.
    assign all_zero = (w_win[LOG-1] == '0);
    assign count    = all_zero ? RESULT_W'(WIDTH) : {1'b0, w_cnt};

endmodule

`default_nettype wire

// File: rtl/bit_scan_unit.sv
// ============================================================================
// bit_scan_unit : two-stage CLZ/CLO/CTZ/CTO unit with valid/ready and flush
// Revision 1.0
// ============================================================================
`default_nettype none

module bit_scan_unit
    import bit_scan_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int RESULT_W = $clog2(WIDTH) + 1,
    parameter int TAG_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_mode,
    input  logic [WIDTH-1:0]    i_data,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_all,
    output logic [TAG_W-1:0]    o_tag
);

    logic                s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]    s1_word_q,  s1_word_d;
    logic [TAG_W-1:0]    s1_tag_q,   s1_tag_d;
    logic                s2_valid_q, s2_valid_d;
    logic [RESULT_W-1:0] result_q,   result_d;
    logic                all_q,      all_d;
    logic [TAG_W-1:0]    tag_q,      tag_d;

    logic                w_s2_adv, w_s1_adv, w_accept;
    logic                w_ones, w_trailing;
    logic [WIDTH-1:0]    w_inv, w_rev, w_word;
    logic [MAX_W-1:0]    w_rev_full;
    logic [RESULT_W-1:0] w_count;
    logic                w_all;

    assign w_s2_adv = ~s2_valid_q | i_ready;
    assign w_s1_adv = s1_valid_q & w_s2_adv;
    assign o_ready  = ~reset & (~s1_valid_q | w_s2_adv);
    assign w_accept = i_valid & o_ready;

    // Every mode is folded into a leading-zero count of the transformed word.
    assign w_ones     = (i_mode == MODE_CLO) | (i_mode == MODE_CTO);
    assign w_trailing = (i_mode == MODE_CTZ) | (i_mode == MODE_CTO);
    assign w_inv      = w_ones ? ~i_data : i_data;
    assign w_rev_full = bit_reverse(MAX_W'(w_inv), WIDTH);
    assign w_rev      = w_rev_full[WIDTH-1:0];
    assign w_word     = w_trailing ? w_rev : w_inv;

    if (WIDTH < MAX_W) begin : g_rev_pad
        logic w_unused_rev;
        assign w_unused_rev = ^w_rev_full[MAX_W-1:WIDTH];
    end

    lzc_tree #(
        .WIDTH    (WIDTH),
        .RESULT_W (RESULT_W)
    ) u_lzc (
        .data     (s1_word_q),
        .count    (w_count),
        .all_zero (w_all)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        all_d      = all_q;
        tag_d      = tag_q;

        if (w_s1_adv) begin
            s2_valid_d = 1'b1;
            result_d   = w_count;
            all_d      = w_all;
            tag_d      = s1_tag_q;
        end else if (i_ready) begin
            s2_valid_d = 1'b0;
        end

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_word_d  = w_word;
            s1_tag_d   = i_tag;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (i_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            all_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            all_q      <= all_d;
            tag_q      <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_word_q <= s1_word_d;
        s1_tag_q  <= s1_tag_d;
    end

    assign o_valid  = s2_valid_q;
    assign o_result = result_q;
    assign o_all    = all_q;
    assign o_tag    = tag_q;

endmodule

`default_nettype wire
